uc_fsm: RTL and testbench

- Control unit for the single-cycle microc datapath.
- Consumes the datapath's 6-bit opcode and zero flag, and drives its control inputs: s_inc, s_inm, we3, wez and Op.
- Adds a RUN/HALT state machine with sticky illegal-opcode capture, plus optional performance counters.
- Sits directly upstream of microc's control inputs; it is the block that replaces the hand-driven control stimulus.

---
 rtl/uc_pkg.sv | 25 ++
 rtl/uc_decode.sv | 53 +++++
 rtl/uc_fsm.sv | 115 +++++++++++
 tb/tb_uc_fsm.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the microc control unit.
//   - opcode field constants used by the decoder
//   - ALU operation codes
//   - FSM state encoding
package uc_pkg;

  // Opcode fields
  localparam logic [5:0] OPC_J      = 6'b000000;
  localparam logic [5:0] OPC_JZ     = 6'b000010;
  localparam logic [5:0] OPC_JNZ    = 6'b000011;
  localparam logic [3:0] OPC_LI_PFX = 4'b0001;
  localparam int         ALU_BIT    = 5;

  // ALU operation codes (opcode[4:2] of an ALU instruction)
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;

  // FSM states
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/uc_decode.sv
// uc_decode: purely combinational opcode/z to control-word decoder.
// Ports:
//   opcode - 6-bit instruction opcode
//   z      - zero flag from the datapath
//   s_inc  - 1 = PC+1, 0 = load jump address
//   s_inm  - 1 = write immediate, 0 = write ALU result
//   we3    - register-bank write enable
//   wez    - z-flag write enable
//   op     - ALU operation
//   legal  - opcode is a defined instruction
// Illegal opcodes decode to the safe control word with legal=0.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] op,
  output logic       legal
);

  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    op    = ALU_PASS;
    legal = 1'b0;
    if (opcode[ALU_BIT]) begin
      op    = opcode[4:2];
      we3   = 1'b1;
      wez   = 1'b1;
      legal = 1'b1;
    end else if (opcode[5:2] == OPC_LI_PFX) begin
      s_inm = 1'b1;
      we3   = 1'b1;
      legal = 1'b1;
    end else if (opcode == OPC_J) begin
      s_inc = 1'b0;
      legal = 1'b1;
    end else if (opcode == OPC_JZ) begin
      s_inc = ~z;
      legal = 1'b1;
    end else if (opcode == OPC_JNZ) begin
      s_inc = z;
      legal = 1'b1;
    end
  end

endmodule

// File: rtl/uc_fsm.sv
// uc_fsm: control unit for the single-cycle microc datapath.
// Decodes opcode/z into the datapath control inputs and adds a RUN/HALT
// state machine with sticky capture of the first illegal opcode.
// Optional feature macro: UC_PERF_CNT_EN (performance counters). When
// undefined, instr_cnt/taken_cnt are tied to zero.
// Ports:
//   clk, reset          - clock (rising edge), synchronous active-high reset
//   opcode, z           - opcode and zero flag from the datapath
//   s_inc, s_inm, we3,
//   wez, Op             - datapath control outputs
//   halted              - FSM is in HALT
//   illegal, err_opcode - sticky illegal flag and first illegal opcode
//   instr_cnt           - retired instruction count (saturating)
//   taken_cnt           - taken jump count (saturating)
module uc_fsm
  import uc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             z,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             halted,
  output logic             illegal,
  output logic [5:0]       err_opcode,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  logic       d_s_inc, d_s_inm, d_we3, d_wez, d_legal;
  logic [2:0] d_op;
  logic       run_ok;
  state_t     state, state_nxt;

  uc_decode u_decode (
    .opcode (opcode),
    .z      (z),
    .s_inc  (d_s_inc),
    .s_inm  (d_s_inm),
    .we3    (d_we3),
    .wez    (d_wez),
    .op     (d_op),
    .legal  (d_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Only a legal opcode in RUN outside reset reaches the datapath; every
  // other case drives the safe word so no partial write can occur.
  always_comb begin
    state_nxt = state;
    run_ok    = 1'b0;
    s_inc     = 1'b1;
    s_inm     = 1'b0;
    we3       = 1'b0;
    wez       = 1'b0;
    Op        = ALU_PASS;
    if (state == ST_RUN) begin
      if (!d_legal) state_nxt = ST_HALT;
      run_ok = d_legal && !reset;
    end
    if (run_ok) begin
      s_inc = d_s_inc;
      s_inm = d_s_inm;
      we3   = d_we3;
      wez   = d_wez;
      Op    = d_op;
    end
  end

  assign halted = (state == ST_HALT);

  // HALT exits only through reset, which also clears illegal, so the
  // !illegal guard makes err_opcode hold the first offender.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal    <= 1'b0;
      err_opcode <= 6'b000000;
    end else if (state == ST_RUN && !d_legal && !illegal) begin
      illegal    <= 1'b1;
      err_opcode <= opcode;
    end
  end

`ifdef UC_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A legal non-jump always has s_inc=1, so s_inc=0 on a retired
  // instruction identifies a taken jump.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt <= '0;
      taken_cnt <= '0;
    end else if (run_ok) begin
      instr_cnt <= sat_inc(instr_cnt);
      if (!d_s_inc) taken_cnt <= sat_inc(taken_cnt);
    end
  end
`else
  assign instr_cnt = '0;
  assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_uc_fsm.sv
module tb_uc_fsm;

`ifdef UC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        z;
  logic        s_inc, s_inm, we3, wez;
  logic [2:0]  Op;
  logic        halted, illegal;
  logic [5:0]  err_opcode;
  logic [15:0] instr_cnt, taken_cnt;

  logic        s_inc2, s_inm2, we32, wez2;
  logic [2:0]  Op2;
  logic        halted2, illegal2;
  logic [5:0]  err_opcode2;
  logic [1:0]  instr_cnt2, taken_cnt2;

  always #5 clk = ~clk;

  uc_fsm #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .halted(halted), .illegal(illegal), .err_opcode(err_opcode),
    .instr_cnt(instr_cnt), .taken_cnt(taken_cnt)
  );

  uc_fsm #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z),
    .s_inc(s_inc2), .s_inm(s_inm2), .we3(we32), .wez(wez2), .Op(Op2),
    .halted(halted2), .illegal(illegal2), .err_opcode(err_opcode2),
    .instr_cnt(instr_cnt2), .taken_cnt(taken_cnt2)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit       m_halt, m_ill;
  bit [5:0] m_err;
  int       m_ic, m_tc, m_ic2, m_tc2;

  typedef struct {
    logic       r;
    logic [5:0] o;
    logic       z;
    logic [6:0] ctl;   // {s_inc, s_inm, we3, wez, Op}
    logic       h;
    logic       il;
    logic [5:0] err;
  } vec_t;

  vec_t tab [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {legal, s_inc, s_inm, we3, wez, Op} from the instruction-set rules
  function automatic logic [7:0] ref_decode(input logic [5:0] o, input logic zz);
    casez (o)
      6'b1?????: return {1'b1, 4'b1011, o[4:2]};
      6'b0001??: return {1'b1, 4'b1110, 3'b000};
      6'b000000: return {1'b1, 4'b0000, 3'b000};
      6'b000010: return {1'b1, ~zz, 3'b000, 3'b000};
      6'b000011: return {1'b1, zz, 3'b000, 3'b000};
      default:   return {1'b0, 4'b1000, 3'b000};
    endcase
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic step(input logic r, input logic [5:0] o, input logic zz,
                      input bit use_tab, input vec_t v);
    logic [7:0] d;
    logic [6:0] ectl;
    bit         retire;
    reset  = r;
    opcode = o;
    z      = zz;
    @(negedge clk);
    d      = ref_decode(o, zz);
    retire = !r && !m_halt && d[7];
    ectl   = retire ? d[6:0] : 7'b1000000;
    chk("ctl", {s_inc, s_inm, we3, wez, Op}, {25'd0, ectl});
    chk("halted", halted, m_halt);
    chk("illegal", illegal, m_ill);
    chk("err_opcode", err_opcode, m_err);
    chk("instr_cnt", instr_cnt, PERF ? m_ic : 0);
    chk("taken_cnt", taken_cnt, PERF ? m_tc : 0);
    chk("instr_cnt2", instr_cnt2, PERF ? m_ic2 : 0);
    chk("taken_cnt2", taken_cnt2, PERF ? m_tc2 : 0);
    if (use_tab) begin
      chk("tab_ctl", {s_inc, s_inm, we3, wez, Op}, {25'd0, v.ctl});
      chk("tab_halted", halted, v.h);
      chk("tab_illegal", illegal, v.il);
      chk("tab_err", err_opcode, v.err);
    end
    @(posedge clk);
    if (r) begin
      m_halt = 0; m_ill = 0; m_err = 0;
      m_ic = 0; m_tc = 0; m_ic2 = 0; m_tc2 = 0;
    end else if (!m_halt) begin
      if (d[7]) begin
        m_ic  = sat(m_ic, 65535);
        m_ic2 = sat(m_ic2, 3);
        if (!d[6]) begin
          m_tc  = sat(m_tc, 65535);
          m_tc2 = sat(m_tc2, 3);
        end
      end else begin
        m_halt = 1;
        if (!m_ill) begin
          m_ill = 1;
          m_err = o;
        end
      end
    end
    #1;
  endtask

  task automatic go(input logic r, input logic [5:0] o, input logic zz);
    vec_t nv;
    nv = '{r: 1'b0, o: 6'd0, z: 1'b0, ctl: 7'd0, h: 1'b0, il: 1'b0, err: 6'd0};
    step(r, o, zz, 1'b0, nv);
  endtask

  initial begin
    vec_t       nv;
    logic [5:0] ro;
    logic       rr, rz;

    tab[0]  = '{1'b1, 6'b101000, 1'b0, 7'b1000000, 1'b0, 1'b0, 6'b000000};
    tab[1]  = '{1'b0, 6'b101000, 1'b0, 7'b1011010, 1'b0, 1'b0, 6'b000000};
    tab[2]  = '{1'b0, 6'b000101, 1'b0, 7'b1110000, 1'b0, 1'b0, 6'b000000};
    tab[3]  = '{1'b0, 6'b000000, 1'b0, 7'b0000000, 1'b0, 1'b0, 6'b000000};
    tab[4]  = '{1'b0, 6'b000011, 1'b0, 7'b0000000, 1'b0, 1'b0, 6'b000000};
    tab[5]  = '{1'b0, 6'b000011, 1'b1, 7'b1000000, 1'b0, 1'b0, 6'b000000};
    tab[6]  = '{1'b0, 6'b000010, 1'b1, 7'b0000000, 1'b0, 1'b0, 6'b000000};
    tab[7]  = '{1'b0, 6'b000010, 1'b0, 7'b1000000, 1'b0, 1'b0, 6'b000000};
    tab[8]  = '{1'b0, 6'b011100, 1'b0, 7'b1000000, 1'b0, 1'b0, 6'b000000};
    tab[9]  = '{1'b0, 6'b001000, 1'b0, 7'b1000000, 1'b1, 1'b1, 6'b011100};
    tab[10] = '{1'b0, 6'b101100, 1'b0, 7'b1000000, 1'b1, 1'b1, 6'b011100};
    tab[11] = '{1'b1, 6'b101100, 1'b0, 7'b1000000, 1'b1, 1'b1, 6'b011100};
    tab[12] = '{1'b0, 6'b101100, 1'b0, 7'b1011011, 1'b0, 1'b0, 6'b000000};
    tab[13] = '{1'b0, 6'b000001, 1'b0, 7'b1000000, 1'b0, 1'b0, 6'b000000};
    tab[14] = '{1'b0, 6'b100000, 1'b0, 7'b1000000, 1'b1, 1'b1, 6'b000001};
    tab[15] = '{1'b1, 6'b000000, 1'b0, 7'b1000000, 1'b1, 1'b1, 6'b000001};
    tab[16] = '{1'b0, 6'b110100, 1'b0, 7'b1011101, 1'b0, 1'b0, 6'b000000};

    // First reset cycle: registers are unknown before it, so nothing is compared.
    reset = 1'b1; opcode = 6'b101000; z = 1'b0;
    @(posedge clk); #1;
    m_halt = 0; m_ill = 0; m_err = 0;
    m_ic = 0; m_tc = 0; m_ic2 = 0; m_tc2 = 0;

    for (int i = 0; i < 17; i++) step(tab[i].r, tab[i].o, tab[i].z, 1'b1, tab[i]);

    // Performance program: li, li, add, sub, jnz(z=0), add, sub, jnz(z=1)
    go(1'b1, 6'b000000, 1'b0);
    go(1'b0, 6'b000100, 1'b0);
    go(1'b0, 6'b000111, 1'b0);
    go(1'b0, 6'b101000, 1'b0);
    go(1'b0, 6'b101100, 1'b0);
    go(1'b0, 6'b000011, 1'b0);
    go(1'b0, 6'b101000, 1'b1);
    go(1'b0, 6'b101100, 1'b1);
    go(1'b0, 6'b000011, 1'b1);
    chk("prog_instr_cnt", instr_cnt, PERF ? 32'd8 : 32'd0);
    chk("prog_taken_cnt", taken_cnt, PERF ? 32'd1 : 32'd0);
    chk("prog_instr_cnt_sat", instr_cnt2, PERF ? 32'd3 : 32'd0);
    chk("prog_taken_cnt2", taken_cnt2, PERF ? 32'd1 : 32'd0);

    // Reset clears counters
    go(1'b1, 6'b101000, 1'b0);
    chk("cnt_after_reset", {instr_cnt, taken_cnt}, 32'd0);

    // Randomized run against the reference model
    for (int n = 0; n < 400; n++) begin
      rr = ($urandom_range(0, 29) == 0);
      rz = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0:       ro = 6'($urandom);
        1, 2, 3: ro = {1'b1, 5'($urandom)};
        4, 5:    ro = {4'b0001, 2'($urandom)};
        6:       ro = 6'b000000;
        default: ro = {5'b00001, 1'($urandom)};
      endcase
      nv = tab[0];
      step(rr, ro, rz, 1'b0, nv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
